// File: rtl/msg_pad_param_if.sv
// ---------------------------------------------------------------------------
// msg_pad_param_if
// Bundle of the three handshake channels of the message padder.
//   cfg  : cfg_size / cfg_valid / cfg_ready       (message length in bits)
//   in   : data_in / data_in_last / data_in_valid / data_in_ready
//   out  : data_out / data_out_last / data_out_valid / data_out_ready
//   stat : err_last (input last-marker mismatch flag)
// Modports:
//   master : producer/consumer side (drives cfg, input words, output ready)
//   slave  : padder side
// ---------------------------------------------------------------------------
interface msg_pad_param_if #(
   parameter int BLOCK_W = 512,
   parameter int LEN_W   = 64
);
   logic [BLOCK_W-1:0] data_in;
   logic               data_in_last;
   logic               data_in_valid;
   logic               data_in_ready;
   logic [LEN_W-1:0]   cfg_size;
   logic               cfg_valid;
   logic               cfg_ready;
   logic [BLOCK_W-1:0] data_out;
   logic               data_out_last;
   logic               data_out_valid;
   logic               data_out_ready;
   logic               err_last;

   modport master (
      output data_in, data_in_last, data_in_valid, cfg_size, cfg_valid, data_out_ready,
      input  data_in_ready, cfg_ready, data_out, data_out_last, data_out_valid, err_last
   );

   modport slave (
      input  data_in, data_in_last, data_in_valid, cfg_size, cfg_valid, data_out_ready,
      output data_in_ready, cfg_ready, data_out, data_out_last, data_out_valid, err_last
   );
endinterface

// File: rtl/msg_pad_param.sv
// ---------------------------------------------------------------------------
// msg_pad_param
// Parametrised hash message padder (SHA-256: 512/64, SHA-512: 1024/128).
// Takes a config word holding the message size in bits, then ceil(size/BLOCK_W)
// message words (first message bit at MSB), and emits the padded block stream:
// message bits, a single '1' end marker, zero fill and the big-endian bit length
// in the low LEN_W bits of the final block. 1 word/cycle, 1 cycle latency.
//
// Ports:
//   clk        : clock, rising edge
//   sync_rst   : synchronous active-high reset, returns to IDLE and drops the
//                output word in flight
//   bus        : msg_pad_param_if.slave (cfg, input and output channels, err_last)
//
// Build option:
//   MSG_PAD_LAST_CHECK_EN : when defined, err_last flags a data_in_last marker
//                           that disagrees with the word count derived from
//                           cfg_size (sticky until next cfg accept / reset).
//                           When undefined, data_in_last is ignored, err_last=0.
// ---------------------------------------------------------------------------
module msg_pad_param #(
   parameter int BLOCK_W = 512,
   parameter int LEN_W   = 64
) (
   input logic            clk,
   input logic            sync_rst,
   msg_pad_param_if.slave bus
);
   localparam int R     = $clog2(BLOCK_W);
   localparam int CNT_W = LEN_W - R;
   // Largest partial-word bit count that still leaves room for marker + length.
   localparam logic [R-1:0] FIT_MAX = R'(BLOCK_W - LEN_W - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_LAST,
      ST_EXTRA
   } state_t;

   state_t state_q, state_d;

   logic [LEN_W-1:0]   size_q;
   logic [R-1:0]       rem_q;
   logic [CNT_W-1:0]   cnt_q;

   logic               out_valid_p0;
   logic               out_last_p0;
   logic [BLOCK_W-1:0] out_data_p0;

   logic               adv;
   logic               cfg_ready;
   logic               in_ready;
   logic               load;
   logic [BLOCK_W-1:0] word_d;
   logic               last_d;
   logic               fit;
   logic               cfg_fire;
   logic               in_fire;
   logic [R-1:0]       cfg_rem;
   logic [CNT_W-1:0]   cfg_n;

   // Final message word: keep the top rem bits, place the end marker right
   // after them, clear the rest. A full word (rem==0) passes unchanged.
   function automatic logic [BLOCK_W-1:0] pad_last(input logic [BLOCK_W-1:0] w,
                                                   input logic [R-1:0]       rem);
      logic [BLOCK_W-1:0] keep;
      logic [BLOCK_W-1:0] marker;
      keep   = ~({BLOCK_W{1'b1}} >> rem);
      marker = {1'b1, {(BLOCK_W-1){1'b0}}} >> rem;
      if (rem == '0) begin
         return w;
      end
      return (w & keep) | marker;
   endfunction

   function automatic logic [BLOCK_W-1:0] len_field(input logic [LEN_W-1:0] size);
      return {{(BLOCK_W-LEN_W){1'b0}}, size};
   endfunction

   assign adv      = !out_valid_p0 || bus.data_out_ready;
   assign cfg_rem  = bus.cfg_size[R-1:0];
   assign cfg_n    = bus.cfg_size[LEN_W-1:R] + CNT_W'(cfg_rem != '0);
   assign fit      = (rem_q != '0) && (rem_q <= FIT_MAX);
   assign cfg_fire = bus.cfg_valid && cfg_ready;
   assign in_fire  = bus.data_in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (sync_rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cfg_ready = 1'b0;
      in_ready  = 1'b0;
      load      = 1'b0;
      word_d    = bus.data_in;
      last_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cfg_ready = 1'b1;
            if (bus.cfg_valid) begin
               if (cfg_n >= CNT_W'(2)) begin
                  state_d = ST_DATA;
               end else if (cfg_n == CNT_W'(1)) begin
                  state_d = ST_LAST;
               end else begin
                  state_d = ST_EXTRA;
               end
            end
         end
         ST_DATA: begin
            in_ready = adv;
            if (bus.data_in_valid && adv) begin
               load = 1'b1;
               // cnt_q counts words still to come including this one.
               if (cnt_q == CNT_W'(2)) begin
                  state_d = ST_LAST;
               end
            end
         end
         ST_LAST: begin
            in_ready = adv;
            word_d   = pad_last(bus.data_in, rem_q);
            if (fit) begin
               word_d = word_d | len_field(size_q);
            end
            last_d = fit;
            if (bus.data_in_valid && adv) begin
               load    = 1'b1;
               state_d = fit ? ST_IDLE : ST_EXTRA;
            end
         end
         ST_EXTRA: begin
            // Marker lands here only when the message ended on a word boundary.
            word_d              = len_field(size_q);
            word_d[BLOCK_W-1]   = (rem_q == '0);
            last_d              = 1'b1;
            if (adv) begin
               load    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (cfg_fire) begin
         size_q <= bus.cfg_size;
         rem_q  <= cfg_rem;
         cnt_q  <= cfg_n;
      end else if (in_fire) begin
         cnt_q  <= cnt_q - CNT_W'(1);
      end
   end

   // ---- stage p0: registered output block ----
   always_ff @(posedge clk) begin
      if (sync_rst) begin
         out_valid_p0 <= 1'b0;
         out_last_p0  <= 1'b0;
         out_data_p0  <= '0;
      end else if (adv) begin
         out_valid_p0 <= load;
         if (load) begin
            out_data_p0 <= word_d;
            out_last_p0 <= last_d;
         end
      end
   end

   assign bus.cfg_ready      = cfg_ready;
   assign bus.data_in_ready  = in_ready;
   assign bus.data_out       = out_data_p0;
   assign bus.data_out_last  = out_last_p0;
   assign bus.data_out_valid = out_valid_p0;

`ifdef MSG_PAD_LAST_CHECK_EN
   logic err_q;

   // The word accepted in LAST is always the Nth; every earlier one is not.
   always_ff @(posedge clk) begin
      if (sync_rst) begin
         err_q <= 1'b0;
      end else if (cfg_fire) begin
         err_q <= 1'b0;
      end else if (in_fire && (bus.data_in_last != (state_q == ST_LAST))) begin
         err_q <= 1'b1;
      end
   end

   assign bus.err_last = err_q;
`else
   logic unused_last;
   assign unused_last  = bus.data_in_last;
   assign bus.err_last = 1'b0;
`endif

endmodule

// File: tb/tb_msg_pad_param.sv
// ---------------------------------------------------------------------------
// tb_msg_pad_param
// Self-checking bench for msg_pad_param (BLOCK_W=512, LEN_W=64). Expected
// blocks come from a bit-level model of standard hash padding: the padded
// stream is the message, one '1' bit, zeros, and the 64-bit length at the end
// of the last block, with block count ceil((size+1+LEN_W)/BLOCK_W).
// ---------------------------------------------------------------------------
module tb_msg_pad_param;
   localparam int BW = 512;
   localparam int LW = 64;

   logic clk = 1'b0;
   logic sync_rst;

   always #5 clk = ~clk;

   msg_pad_param_if #(.BLOCK_W(BW), .LEN_W(LW)) bus ();

   msg_pad_param #(.BLOCK_W(BW), .LEN_W(LW)) dut (
      .clk      (clk),
      .sync_rst (sync_rst),
      .bus      (bus)
   );

   int   checks = 0;
   int   errors = 0;
   logic err_model = 1'b0;

   task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [BW-1:0] rand_word();
      logic [BW-1:0] w;
      for (int j = 0; j < BW / 32; j++) begin
         w[j*32 +: 32] = $urandom;
      end
      return w;
   endfunction

   // Block b (0-based) of an m-block padded message; word is message word b
   // (zero when past the message).
   function automatic logic [BW-1:0] exp_block(input logic [LW-1:0] size, input int b,
                                               input int m, input logic [BW-1:0] word);
      logic [BW-1:0] blk;
      longint        g;
      blk = '0;
      for (int k = 0; k < BW; k++) begin
         g = longint'(b) * BW + k;
         if (g < longint'(size)) begin
            blk[BW-1-k] = word[BW-1-k];
         end else if (g == longint'(size)) begin
            blk[BW-1-k] = 1'b1;
         end else if (b == m - 1 && k >= BW - LW) begin
            blk[BW-1-k] = size[BW-1-k];
         end
      end
      return blk;
   endfunction

   // mode bit0: random input gaps, bit1: random output ready,
   // bit2: output ready low for cycles 3..7.
   // pattern 0: random words, 1: "abc", 2: alternating AA../55..
   task automatic run_msg(input logic [LW-1:0] size, input int mode, input int bad_idx,
                          input int pattern, input bit use_golden, input logic [BW-1:0] golden0);
      logic [BW-1:0] words[$];
      logic [BW-1:0] w;
      logic [BW-1:0] prev_data;
      int            n, m, idx, got, cyc, last_fire_cyc;
      bit            prev_hold, prev_in_fire, rdy, in_fire, out_fire;

      n = int'((longint'(size) + BW - 1) / BW);
      m = int'((longint'(size) + 1 + LW + BW - 1) / BW);
      for (int i = 0; i < n; i++) begin
         if (pattern == 1) begin
            w = '0;
            w[BW-1 -: 24] = 24'h616263;
         end else if (pattern == 2) begin
            w = (i % 2 == 0) ? {(BW/8){8'hAA}} : {(BW/8){8'h55}};
         end else begin
            w = rand_word();
         end
         words.push_back(w);
      end

      idx = 0; got = 0; cyc = 0; last_fire_cyc = -1;
      prev_hold = 1'b0; prev_in_fire = 1'b0; prev_data = '0;
      while (got < m && cyc < 400) begin
         @(negedge clk);
         bus.cfg_valid     = (cyc == 0);
         bus.cfg_size      = size;
         bus.data_in_valid = (mode & 1) ? ($urandom_range(0, 1) == 1) : 1'b1;
         bus.data_in       = (idx < n) ? words[idx] : rand_word();
         bus.data_in_last  = (idx == n - 1) ^ (idx == bad_idx);
         if (mode & 4)      rdy = !(cyc >= 3 && cyc < 8);
         else if (mode & 2) rdy = ($urandom_range(0, 1) == 1);
         else               rdy = 1'b1;
         bus.data_out_ready = rdy;
         #1;
         if (cyc == 0) begin
            check("cfg_ready_idle", bus.cfg_ready, 1'b1);
            check("idle_in_ready", bus.data_in_ready, 1'b0);
         end
         if (prev_hold)    check("out_hold", bus.data_out, prev_data);
         if (prev_in_fire) check("latency_valid", bus.data_out_valid, 1'b1);
         if (bus.data_out_valid && !rdy) check("stall_in_ready", bus.data_in_ready, 1'b0);
         check("err_last", bus.err_last, err_model);

         in_fire  = bus.data_in_valid && bus.data_in_ready;
         out_fire = bus.data_out_valid && rdy;
         if (out_fire) begin
            check("block", bus.data_out, exp_block(size, got, m, (got < n) ? words[got] : '0));
            check("block_last", bus.data_out_last, (got == m - 1));
            if (use_golden && got == 0) check("golden_block", bus.data_out, golden0);
            if (got == m - 1) last_fire_cyc = cyc;
            got++;
         end
         prev_hold    = bus.data_out_valid && !rdy;
         prev_data    = bus.data_out;
         prev_in_fire = in_fire;
`ifdef MSG_PAD_LAST_CHECK_EN
         if (cyc == 0) err_model = 1'b0;
         else if (in_fire && (bus.data_in_last != (idx == n - 1))) err_model = 1'b1;
`endif
         if (in_fire) idx++;
         cyc++;
      end
      check("blocks_emitted", BW'(got), BW'(m));
      check("words_accepted", BW'(idx), BW'(n));
      if ((mode & 3) == 0) begin
         check("throughput", BW'(last_fire_cyc), BW'(m + 1 + ((mode & 4) ? 5 : 0)));
      end
      @(negedge clk);
      bus.cfg_valid      = 1'b0;
      bus.data_in_valid  = 1'b0;
      bus.data_out_ready = 1'b1;
      #1;
      check("post_cfg_ready", bus.cfg_ready, 1'b1);
      check("post_out_valid", bus.data_out_valid, 1'b0);
   endtask

   initial begin
      logic [BW-1:0] g;
      sync_rst           = 1'b1;
      bus.data_in        = '0;
      bus.data_in_last   = 1'b0;
      bus.data_in_valid  = 1'b0;
      bus.cfg_size       = '0;
      bus.cfg_valid      = 1'b0;
      bus.data_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      sync_rst = 1'b0;
      #1;
      check("rst_cfg_ready", bus.cfg_ready, 1'b1);
      check("rst_in_ready", bus.data_in_ready, 1'b0);
      check("rst_out_valid", bus.data_out_valid, 1'b0);
      check("rst_out_data", bus.data_out, '0);
      check("rst_out_last", bus.data_out_last, 1'b0);
      check("rst_err_last", bus.err_last, 1'b0);

      // "abc" single block
      g = '0;
      g[BW-1 -: 32] = 32'h61626380;
      g[LW-1:0]     = 64'h18;
      run_msg(64'd24, 0, -1, 1, 1'b1, g);
      // fit boundary
      g = '0;
      g[64]     = 1'b1;
      run_msg(64'd447, 0, -1, 0, 1'b0, g);
      run_msg(64'd448, 0, -1, 0, 1'b0, g);
      // two full words plus extra block
      run_msg(64'd1024, 0, -1, 2, 1'b0, g);
      // zero length
      g = '0;
      g[BW-1] = 1'b1;
      run_msg(64'd0, 0, -1, 0, 1'b1, g);
      // output stall mid-stream
      run_msg(64'd2048, 4, -1, 0, 1'b0, g);
      run_msg(64'd512, 0, -1, 0, 1'b0, g);
      run_msg(64'd1, 0, -1, 0, 1'b0, g);
      // random sizes with random input/output gaps
      for (int i = 0; i < 8; i++) begin
         run_msg(LW'($urandom_range(0, 3000)), 3, -1, 0, 1'b0, g);
      end

      // reset mid-message
      @(negedge clk);
      bus.cfg_size  = 64'd2048;
      bus.cfg_valid = 1'b1;
      @(negedge clk);
      bus.cfg_valid      = 1'b0;
      bus.data_in_valid  = 1'b1;
      bus.data_in        = rand_word();
      bus.data_out_ready = 1'b1;
      repeat (3) @(negedge clk);
      sync_rst = 1'b1;
      @(negedge clk);
      sync_rst = 1'b0;
      err_model = 1'b0;
      #1;
      check("midrst_cfg_ready", bus.cfg_ready, 1'b1);
      check("midrst_out_valid", bus.data_out_valid, 1'b0);
      check("midrst_out_data", bus.data_out, '0);
      check("midrst_in_ready", bus.data_in_ready, 1'b0);
      bus.data_in_valid = 1'b0;
      run_msg(64'd100, 0, -1, 0, 1'b0, g);

      // early data_in_last on word 0, then a clean message clears the flag
      run_msg(64'd1024, 0, 0, 0, 1'b0, g);
`ifdef MSG_PAD_LAST_CHECK_EN
      check("err_sticky", bus.err_last, 1'b1);
`else
      check("err_tied", bus.err_last, 1'b0);
`endif
      run_msg(64'd300, 0, -1, 0, 1'b0, g);
      check("err_cleared", bus.err_last, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/msg_pad_param.md
Name: msg_pad_param

Overview:
Parametrised message-padding stage for the hash accelerator datapath, generalising the fixed 512-bit/64-bit padder to BLOCK_W-bit blocks with an LEN_W-bit length field (SHA-256: 512/64, SHA-512: 1024/128).
- Consumes a config word (message size in bits) and ceil(size/BLOCK_W) input words.
- Emits padded blocks: end marker, zero fill and big-endian length in the low LEN_W bits of the final block.
- Sits between the input DMA/stream and the hash compression core.
- Full 1 word/cycle throughput and defined zero-length handling.

Parameters:
- BLOCK_W, 512, block/data word width in bits; power of two, >= 256.
- LEN_W, 64, width of the cfg_size field and of the appended length field; LEN_W < BLOCK_W.

Ports:
- clk, in, 1, clock; all logic on rising edge.
- sync_rst, in, 1, reset; synchronous, active-high.
- data_in, in, BLOCK_W, message word; first message bit at MSB.
- data_in_last, in, 1, producer's end-of-message marker.
- data_in_valid, in, 1, input valid.
- data_in_ready, out, 1, input ready.
- cfg_size, in, LEN_W, message length in bits.
- cfg_valid, in, 1, config valid.
- cfg_ready, out, 1, config ready.
- data_out, out, BLOCK_W, padded block.
- data_out_last, out, 1, final block of the message.
- data_out_valid, out, 1, output valid.
- data_out_ready, in, 1, output ready.
- err_last, out, 1, data_in_last mismatch flag (see Optional Feature).

Behaviour:
- Reset: synchronous, active-high, on sync_rst; all state returns to IDLE immediately, mid-message included, and the in-flight output word is discarded.
  - Reset values: cfg_ready=1, data_in_ready=0, data_out_valid=0, data_out=0, data_out_last=0, err_last=0.
- Handshakes: a transfer occurs when valid && ready on a rising edge. The output register may load when adv = !data_out_valid || data_out_ready.
  - data_out / data_out_last / data_out_valid are registered; latency is 1 cycle from input accept to output valid.
  - Throughput is 1 word/cycle under continuous ready.
- Derived values: R = log2(BLOCK_W); rem = size[R-1:0]; N = size[LEN_W-1:R] + |rem. The word counter is LEN_W-R bits wide, with no overflow.
- fit = (rem != 0) && (rem <= BLOCK_W-LEN_W-1).
- IDLE: cfg_ready=1, data_in_ready=0.
  - On cfg accept, latch size, N and rem, and drop cfg_ready.
  - Next state: N>=2 -> DATA; N==1 -> LAST; N==0 -> EXTRA.
- DATA: data_in_ready = adv. Each accepted word passes through unchanged with last=0 and decrements the counter. On acceptance of word N-1, go to LAST.
- LAST: data_in_ready = adv. The accepted word is built as follows:
  - rem!=0: keep the top rem bits; set bit BLOCK_W-1-rem; clear all lower bits.
  - rem==0: the word is unchanged.
  - If fit: OR size into the low LEN_W bits, last=1, go to IDLE (cfg_ready=1 next cycle).
  - If not fit: last=0, go to EXTRA.
- EXTRA: data_in_ready=0. When adv, emit {(rem==0), zeros, size[LEN_W-1:0]} with last=1, then go to IDLE.
- Zero-length message: no input word is consumed. One block is emitted: MSB=1, length 0, last=1.
- Input words presented in IDLE or EXTRA are not accepted.
- data_out holds stable while data_out_valid && !data_out_ready.

Optional Feature:
Macro MSG_PAD_LAST_CHECK_EN.
- Defined: err_last is set if data_in_last=1 on any accepted word other than the Nth, or data_in_last=0 on the Nth.
  - err_last is sticky; it clears on the next cfg accept or on sync_rst.
  - Padding still follows N from cfg_size; data_in_last never alters the output stream.
- Undefined: data_in_last is ignored and err_last is tied to 0.

Test Plan (BLOCK_W=512, LEN_W=64):
1. size=24, data_in=0x616263 in bits [511:488] -> one block: 0x61626380, then zeros, low 64 bits = 0x18; data_out_last=1 one cycle after accept; cfg_ready=1 the following cycle.
2. size=447 -> one block with bit 64 set, low 64 bits = 0x1BF, last=1.
   size=448 -> block with bit 63 set and last=0, then block of all zeros except low 64 bits = 0x1C0, last=1.
3. size=1024, two words 0xAA..AA and 0x55..55 -> both pass unchanged with last=0; third block = bit 511 set plus 0x400, last=1.
4. size=0 -> data_in_ready never asserts; one block 0x8000...0000, last=1; cfg_ready returns to 1.
5. size=2048, data_out_ready low for 5 cycles mid-stream -> data_out stable, data_in_ready=0, no word lost or duplicated; 1 block/cycle once ready is high. sync_rst pulsed mid-message -> next cycle cfg_ready=1, data_out_valid=0.
6. MSG_PAD_LAST_CHECK_EN defined, size=1024, data_in_last=1 on word 1 -> err_last=1 from the next cycle, 3 blocks still emitted; next cfg accept clears err_last.
